enemy_grid: RTL and testbench
=============================

Name: enemy_grid

Overview:
- Consumer end of the bullet collision interface: takes the bullet's active flag and its signed bounding box, and resolves hits against a grid of enemies.
- Holds the enemy alive bitmap and the formation position, which marches side to side and drops down.
- Emits a one-cycle bullet_hit pulse so the bullet can be retired, keeps a kill score, and drives the enemy pixel layer that is OR-merged with the bullet and paddle layers.

Parameters:
- COLS, 8, enemy columns.
- ROWS, 4, enemy rows; N = ROWS*COLS ≤ 64.
- ENEMY_W, 16, enemy width in pixels.
- ENEMY_H, 12, enemy height in pixels.
- SPACING_X, 32, column pitch; power of two, > ENEMY_W.
- SPACING_Y, 16, row pitch; power of two, > ENEMY_H.
- START_X, 64, formation left edge after reset.
- START_Y, 48, formation top edge after reset.
- STEP_X, 2, horizontal pixels moved per frame.
- DROP_Y, 8, pixels dropped on each edge bounce.
- HRES, 640, visible width.
- LIMIT_Y, 440, invasion line.
- ENEMY_COLOR, 24'h00FF00, RGB888 colour.

Ports:
- pixel_clk  in  1  pixel clock.
- rst  in  1  reset.
- fsync  in  1  one-cycle frame-start strobe.
- bullet_active  in  1  bullet in flight.
- bullet_left  in  12 signed  bullet box left edge, inclusive.
- bullet_right  in  12 signed  bullet box right edge, inclusive.
- bullet_top  in  12 signed  bullet box top edge, inclusive.
- bullet_bottom  in  12 signed  bullet box bottom edge, inclusive.
- hpos  in  12 signed  current pixel x.
- vpos  in  12 signed  current pixel y.
- pixel  out  3x8  RGB, where [2]=R, [1]=G, [0]=B; zero where no live enemy is drawn.
- bullet_hit  out  1  one-cycle pulse: the bullet struck an enemy.
- score  out  16  kill count.
- all_clear  out  1  every enemy is dead.
- invaded  out  1  formation bottom ≥ LIMIT_Y.

Behaviour:
Reset and clocking:
- Reset rst, synchronous, active-high; clock pixel_clk.
- Reset values: alive = all ones, form_x = START_X, form_y = START_Y, dir = right, state = IDLE, idx = 0, bullet_hit = 0, score = 0.
- all_clear and invaded are combinational from registers, so both are 0 after reset with legal parameters.

Geometry (signed 12-bit arithmetic):
- Enemy (r,c): left = form_x + c*SPACING_X, top = form_y + r*SPACING_Y, right = left + ENEMY_W - 1, bottom = top + ENEMY_H - 1.
- Formation width FW = (COLS-1)*SPACING_X + ENEMY_W.
- Formation height FH = (ROWS-1)*SPACING_Y + ENEMY_H.

FSM states: IDLE, SCAN, HIT.
- IDLE, on fsync:
  - Latch all five bullet inputs.
  - Perform the motion update.
  - Set idx = 0 and go to SCAN.
- Motion update (skipped while all_clear or invaded):
  - dir right: if form_x + FW - 1 + STEP_X > HRES - 1, then dir = left and form_y += DROP_Y; else form_x += STEP_X.
  - dir left: if form_x - STEP_X < 0, then dir = right and form_y += DROP_Y; else form_x -= STEP_X.
  - The scan uses the pre-update form_x/form_y for the whole pass, i.e. the positions that were on screen during the previous frame.
- SCAN: one enemy per cycle, idx = r*COLS + c in row-major order.
  - If the latched bullet_active is 0, return to IDLE immediately.
  - Hit test: alive[idx] and bullet_left ≤ right and bullet_right ≥ left and bullet_top ≤ bottom and bullet_bottom ≥ top, using the latched box and the pre-update position.
  - Hit -> HIT. Otherwise idx++; after idx = N-1 -> IDLE.
- HIT (exactly one cycle):
  - Clear alive[idx].
  - bullet_hit = 1.
  - score = score + 1, saturating at 16'hFFFF.
  - Go to IDLE.
  - At most one kill per frame: the lowest index wins.

Timing and boundary cases:
- bullet_hit is high only in the cycle after HIT is entered, i.e. registered; latency from fsync is k+2 cycles for a hit at idx k.
- fsync while in SCAN or HIT: restart. Relatch, run the motion update, idx = 0, SCAN. Any pending HIT is abandoned with no kill and no pulse.
- rst mid-scan: all state returns to reset values that cycle; no pulse.
- all_clear = (alive == 0). While all_clear or invaded is high the formation freezes, but scanning continues.
- invaded = form_y + FH - 1 ≥ LIMIT_Y.

Drawing (combinational, zero latency):
- dx = hpos - form_x, dy = vpos - form_y.
- c = dx >> log2(SPACING_X), ox = dx & (SPACING_X-1); r and oy likewise from dy.
- Draw when dx ≥ 0, dy ≥ 0, c < COLS, r < ROWS, ox < ENEMY_W, oy < ENEMY_H and alive[r*COLS+c].
- Drawing uses live form_x/form_y.

Test Plan:
- Reset then 1 fsync with bullet_active=0 -> form_x 64→66, alive=32'hFFFFFFFF, bullet_hit never asserts, score=0.
- Before the first fsync, bullet box L=70, R=72, T=50, B=55, active=1; fsync -> single bullet_hit pulse 2 cycles after fsync (idx 0), alive[0]=0, score=1; pixel at (70,50) is 0 while (102,50) stays green.
- Bullet box overlapping enemies idx 1 and 9 (e.g. L=100, R=102, T=48, B=70 at form_x=64) -> only idx 1 dies, one pulse, score+1.
- Step 1 fsync at a time until form_x+FW-1+STEP_X > 639 -> dir flips, form_y=56, form_x unchanged; the next fsync decreases form_x by 2.
- Second fsync 10 cycles after the first while a hit at idx 20 is pending -> no pulse from the first pass; the rescan kills idx 20 on the second pass, exactly 1 pulse total.
- Kill all 32 via repeated targeted frames -> all_clear=1 and score=32; further fsyncs leave form_x constant.

Source files
------------

// File: rtl/enemy_grid.sv
`default_nettype none
// ============================================================================
//  Module   : enemy_grid
//  Purpose  : Enemy formation. It keeps the alive bitmap and the marching
//             position, resolves one bullet hit per frame by scanning the
//             enemies one per cycle, keeps the kill score and drives the
//             enemy pixel layer.
//  Revision : 1.0  initial release
// ============================================================================
module enemy_grid #(
    parameter int          COLS        = 8,
    parameter int          ROWS        = 4,
    parameter int          ENEMY_W     = 16,
    parameter int          ENEMY_H     = 12,
    parameter int          SPACING_X   = 32,
    parameter int          SPACING_Y   = 16,
    parameter int          START_X     = 64,
    parameter int          START_Y     = 48,
    parameter int          STEP_X      = 2,
    parameter int          DROP_Y      = 8,
    parameter int          HRES        = 640,
    parameter int          LIMIT_Y     = 440,
    parameter logic [23:0] ENEMY_COLOR = 24'h00FF00
) (
    input  logic               pixel_clk,
    input  logic               rst,
    input  logic               fsync,
    input  logic               bullet_active,
    input  logic signed [11:0] bullet_left,
    input  logic signed [11:0] bullet_right,
    input  logic signed [11:0] bullet_top,
    input  logic signed [11:0] bullet_bottom,
    input  logic signed [11:0] hpos,
    input  logic signed [11:0] vpos,
    output logic [2:0][7:0]    pixel,
    output logic               bullet_hit,
    output logic [15:0]        score,
    output logic               all_clear,
    output logic               invaded
);

    localparam int N    = ROWS * COLS;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SHX  = $clog2(SPACING_X);
    localparam int SHY  = $clog2(SPACING_Y);
    localparam int DCW  = 12 - SHX;
    localparam int DRW  = 12 - SHY;
    localparam int FW   = (COLS - 1) * SPACING_X + ENEMY_W;
    localparam int FH   = (ROWS - 1) * SPACING_Y + ENEMY_H;

    localparam logic signed [12:0] c_right_reach = 13'(FW - 1 + STEP_X);
    localparam logic signed [12:0] c_hres_max    = 13'(HRES - 1);
    localparam logic signed [12:0] c_step_ext    = 13'(STEP_X);
    localparam logic signed [12:0] c_fh_m1       = 13'(FH - 1);
    localparam logic signed [12:0] c_limit       = 13'(LIMIT_Y);
    localparam logic signed [11:0] c_ew_m1       = 12'(ENEMY_W - 1);
    localparam logic signed [11:0] c_eh_m1       = 12'(ENEMY_H - 1);
    localparam logic signed [11:0] c_step_x      = 12'(STEP_X);
    localparam logic signed [11:0] c_drop_y      = 12'(DROP_Y);
    localparam logic signed [11:0] c_start_x     = 12'(START_X);
    localparam logic signed [11:0] c_start_y     = 12'(START_Y);
    localparam logic [IDXW-1:0]    c_idx_last    = IDXW'(N - 1);
    localparam logic [CW-1:0]      c_col_last    = CW'(COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_HIT  = 2'd2
    } state_t;

    state_t             r_state;
    logic [N-1:0]       r_alive;
    logic signed [11:0] r_form_x, r_form_y;
    logic               r_dir;              // 0 = moving right, 1 = moving left
    logic [IDXW-1:0]    r_idx;
    logic [CW-1:0]      r_col;
    logic [RW-1:0]      r_row;
    logic               r_bullet_hit;
    logic [15:0]        r_score;
    logic               r_b_act;
    logic signed [11:0] r_b_left, r_b_right, r_b_top, r_b_bottom;
    logic signed [11:0] r_scan_x, r_scan_y; // position that was on screen last frame

    // Box of the enemy currently being scanned, from the frozen scan origin
    logic signed [11:0] w_col_off, w_row_off;
    logic signed [11:0] w_en_left, w_en_right, w_en_top, w_en_bottom;
    logic               w_scan_hit;

    assign w_col_off   = 12'(int'(r_col) * SPACING_X);
    assign w_row_off   = 12'(int'(r_row) * SPACING_Y);
    assign w_en_left   = r_scan_x + w_col_off;
    assign w_en_top    = r_scan_y + w_row_off;
    assign w_en_right  = w_en_left + c_ew_m1;
    assign w_en_bottom = w_en_top + c_eh_m1;
    assign w_scan_hit  = r_alive[r_idx]
                       && (r_b_left   <= w_en_right)
                       && (r_b_right  >= w_en_left)
                       && (r_b_top    <= w_en_bottom)
                       && (r_b_bottom >= w_en_top);

    // Edge detection and status flags, widened by one bit so they cannot wrap
    logic signed [12:0] w_fx_ext, w_fy_ext;
    logic               w_at_right, w_at_left, w_frozen;

    assign w_fx_ext   = $signed({r_form_x[11], r_form_x});
    assign w_fy_ext   = $signed({r_form_y[11], r_form_y});
    assign w_at_right = (w_fx_ext + c_right_reach) > c_hres_max;
    assign w_at_left  = (w_fx_ext - c_step_ext) < 13'sd0;
    assign all_clear  = (r_alive == '0);
    assign invaded    = (w_fy_ext + c_fh_m1) >= c_limit;
    assign w_frozen   = all_clear | invaded;

    // Pixel layer: locate the beam inside the formation grid by shift/mask
    logic signed [11:0] w_dx, w_dy;
    logic [DCW-1:0]     w_dcol;
    logic [DRW-1:0]     w_drow;
    logic [SHX-1:0]     w_ox;
    logic [SHY-1:0]     w_oy;
    logic [IDXW-1:0]    w_draw_idx;
    logic               w_draw;

    assign w_dx       = hpos - r_form_x;
    assign w_dy       = vpos - r_form_y;
    assign w_dcol     = w_dx[11:SHX];
    assign w_drow     = w_dy[11:SHY];
    assign w_ox       = w_dx[SHX-1:0];
    assign w_oy       = w_dy[SHY-1:0];
    assign w_draw_idx = IDXW'(int'(w_drow) * COLS + int'(w_dcol));
    assign w_draw     = !w_dx[11] && !w_dy[11]
                      && (w_dcol < DCW'(COLS)) && (w_drow < DRW'(ROWS))
                      && (w_ox < SHX'(ENEMY_W)) && (w_oy < SHY'(ENEMY_H))
                      && r_alive[w_draw_idx];
    assign pixel      = w_draw ? ENEMY_COLOR : '0;

    assign bullet_hit = r_bullet_hit;
    assign score      = r_score;

    // Frame control: fsync restarts the scan from any state and moves the formation
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_alive      <= '1;
            r_form_x     <= c_start_x;
            r_form_y     <= c_start_y;
            r_dir        <= 1'b0;
            r_idx        <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_bullet_hit <= 1'b0;
            r_score      <= '0;
            r_b_act      <= 1'b0;
            r_b_left     <= '0;
            r_b_right    <= '0;
            r_b_top      <= '0;
            r_b_bottom   <= '0;
            r_scan_x     <= c_start_x;
            r_scan_y     <= c_start_y;
        end else begin
            r_bullet_hit <= 1'b0;
            if (fsync) begin
                r_b_act    <= bullet_active;
                r_b_left   <= bullet_left;
                r_b_right  <= bullet_right;
                r_b_top    <= bullet_top;
                r_b_bottom <= bullet_bottom;
                r_scan_x   <= r_form_x;
                r_scan_y   <= r_form_y;
                if (!w_frozen) begin
                    if (!r_dir) begin
                        if (w_at_right) begin
                            r_dir    <= 1'b1;
                            r_form_y <= r_form_y + c_drop_y;
                        end else begin
                            r_form_x <= r_form_x + c_step_x;
                        end
                    end else begin
                        if (w_at_left) begin
                            r_dir    <= 1'b0;
                            r_form_y <= r_form_y + c_drop_y;
                        end else begin
                            r_form_x <= r_form_x - c_step_x;
                        end
                    end
                end
                r_idx   <= '0;
                r_col   <= '0;
                r_row   <= '0;
                r_state <= S_SCAN;
            end else begin
                case (r_state)
                    S_SCAN: begin
                        if (!r_b_act) begin
                            r_state <= S_IDLE;
                        end else if (w_scan_hit) begin
                            r_state <= S_HIT;
                        end else if (r_idx == c_idx_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                            if (r_col == c_col_last) begin
                                r_col <= '0;
                                r_row <= r_row + 1'b1;
                            end else begin
                                r_col <= r_col + 1'b1;
                            end
                        end
                    end
                    S_HIT: begin
                        r_alive[r_idx] <= 1'b0;
                        r_bullet_hit   <= 1'b1;
                        if (r_score != 16'hFFFF) begin
                            r_score <= r_score + 16'd1;
                        end
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_enemy_grid.sv
`default_nettype none
// ============================================================================
//  Module   : tb_enemy_grid
//  Purpose  : Self-checking bench for enemy_grid: drawing vectors, hit
//             latency, restart, march/bounce, kill-all and invasion.
//  Revision : 1.0  initial release
// ============================================================================
module tb_enemy_grid;

    localparam logic [23:0] GREEN = 24'h00FF00;

    logic               pixel_clk = 1'b0;
    logic               rst = 1'b1;
    logic               fsync = 1'b0;
    logic               bullet_active = 1'b0;
    logic signed [11:0] bullet_left = '0, bullet_right = '0;
    logic signed [11:0] bullet_top = '0, bullet_bottom = '0;
    logic signed [11:0] hpos = '0, vpos = '0;
    logic [2:0][7:0]    pixel;
    logic               bullet_hit;
    logic [15:0]        score;
    logic               all_clear;
    logic               invaded;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_fx, m_fy, m_dir, m_score;
    logic [31:0] m_alive;

    typedef struct {
        int          x;
        int          y;
        logic [23:0] px;
    } vec_t;
    vec_t vt[11];

    enemy_grid dut (
        .pixel_clk    (pixel_clk),
        .rst          (rst),
        .fsync        (fsync),
        .bullet_active(bullet_active),
        .bullet_left  (bullet_left),
        .bullet_right (bullet_right),
        .bullet_top   (bullet_top),
        .bullet_bottom(bullet_bottom),
        .hpos         (hpos),
        .vpos         (vpos),
        .pixel        (pixel),
        .bullet_hit   (bullet_hit),
        .score        (score),
        .all_clear    (all_clear),
        .invaded      (invaded)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic tick;
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit m_invaded();
        return (m_fy + 59) >= 440;
    endfunction

    task automatic model_reset;
        m_fx = 64; m_fy = 48; m_dir = 0; m_score = 0; m_alive = '1;
    endtask

    task automatic model_motion;
        if (m_alive != 0 && !m_invaded()) begin
            if (m_dir == 0) begin
                if (m_fx + 239 + 2 > 639) begin m_dir = 1; m_fy += 8; end
                else m_fx += 2;
            end else begin
                if (m_fx - 2 < 0) begin m_dir = 0; m_fy += 8; end
                else m_fx -= 2;
            end
        end
    endtask

    task automatic do_reset;
        rst = 1'b1; fsync = 1'b0; bullet_active = 1'b0;
        tick; tick;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_pix(input string nm, input int x, input int y, input logic [23:0] exp);
        hpos = 12'(x); vpos = 12'(y);
        #1;
        check(nm, 32'(pixel), 32'(exp));
    endtask

    // Position check through the pixel layer, using the first live enemy
    task automatic check_pos(input string nm, input int ex, input int ey);
        int k = -1;
        for (int i = 0; i < 32; i++) if (k < 0 && m_alive[i]) k = i;
        if (k < 0) k = 0;
        check_pix({nm, " on"},   ex + 32*(k%8),     ey + 16*(k/8),     GREEN);
        check_pix({nm, " left"}, ex + 32*(k%8) - 1, ey + 16*(k/8),     24'h0);
        check_pix({nm, " top"},  ex + 32*(k%8),     ey + 16*(k/8) - 1, 24'h0);
    endtask

    task automatic quick_frame;
        bullet_active = 1'b0;
        fsync = 1'b1; tick; fsync = 1'b0;
        model_motion();
        tick;
    endtask

    task automatic run_frame(input string nm, input int l, input int r, input int t, input int b, input bit act);
        int k = -1, pulses = 0, lat = -1, el, et;
        if (act) begin
            for (int i = 0; i < 32; i++) begin
                el = m_fx + 32*(i%8); et = m_fy + 16*(i/8);
                if (k < 0 && m_alive[i] && l <= el + 15 && r >= el && t <= et + 11 && b >= et) k = i;
            end
        end
        bullet_left = 12'(l); bullet_right = 12'(r);
        bullet_top = 12'(t); bullet_bottom = 12'(b);
        bullet_active = act;
        fsync = 1'b1; tick; fsync = 1'b0;
        model_motion();
        for (int c = 1; c <= 40; c++) begin
            tick;
            if (bullet_hit === 1'b1) begin pulses++; if (lat < 0) lat = c; end
        end
        check({nm, " pulses"}, 32'(pulses), (k >= 0) ? 32'd1 : 32'd0);
        if (k >= 0) begin
            check({nm, " latency"}, 32'(lat), 32'(k + 2));
            m_alive[k] = 1'b0;
            m_score++;
        end
        check({nm, " score"}, 32'(score), 32'(m_score));
    endtask

    initial begin
        int pulses, lat, bx, by;
        logic [11:0] fx_before;

        vt[0]  = '{64,  48,  GREEN};
        vt[1]  = '{79,  48,  GREEN};
        vt[2]  = '{80,  48,  24'h0};
        vt[3]  = '{96,  48,  GREEN};
        vt[4]  = '{63,  48,  24'h0};
        vt[5]  = '{64,  47,  24'h0};
        vt[6]  = '{64,  59,  GREEN};
        vt[7]  = '{64,  60,  24'h0};
        vt[8]  = '{303, 107, GREEN};
        vt[9]  = '{320, 48,  24'h0};
        vt[10] = '{0,   0,   24'h0};

        // Reset state and drawing table
        do_reset();
        check("rst bullet_hit", 32'(bullet_hit), 32'd0);
        check("rst score",      32'(score),      32'd0);
        check("rst all_clear",  32'(all_clear),  32'd0);
        check("rst invaded",    32'(invaded),    32'd0);
        for (int i = 0; i < 11; i++) check_pix($sformatf("draw vec %0d", i), vt[i].x, vt[i].y, vt[i].px);

        // Idle frame, then march to the right edge and bounce
        run_frame("idle frame", 0, 0, 0, 0, 1'b0);
        check_pos("pos after 1", 66, 48);
        for (int f = 0; f < 167; f++) quick_frame();
        check_pos("pos at edge", 400, 48);
        quick_frame();
        check_pos("pos bounce", 400, 56);
        quick_frame();
        check_pos("pos leftward", 398, 56);

        // Reset in the middle of a scan that would hit idx 5
        do_reset();
        bullet_left = 12'd226; bullet_right = 12'd228; bullet_top = 12'd50; bullet_bottom = 12'd52;
        bullet_active = 1'b1; fsync = 1'b1; tick; fsync = 1'b0;
        tick; tick; tick;
        rst = 1'b1; tick; rst = 1'b0;
        bullet_active = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin tick; if (bullet_hit === 1'b1) pulses++; end
        check("midscan rst pulses", 32'(pulses), 32'd0);
        check("midscan rst score",  32'(score),  32'd0);
        model_reset();
        check_pix("midscan enemy5 alive", 224, 48, GREEN);
        check_pos("midscan rst pos", 64, 48);

        // First-enemy hit
        run_frame("hit idx0", 70, 72, 50, 55, 1'b1);
        check("hit idx0 score", 32'(score), 32'd1);
        check_pix("idx0 dark", 70, 50, 24'h0);
        check_pix("idx1 green", 102, 50, GREEN);

        // Box spanning idx 1 and 9: only the lower index dies
        run_frame("hit idx1", 100, 102, 48, 70, 1'b1);
        check("hit idx1 score", 32'(score), 32'd2);
        check_pix("idx1 dark", 100, 50, 24'h0);
        check_pix("idx9 green", 100, 66, GREEN);

        // Restart: second fsync 10 cycles after the first abandons the pending hit
        bx = m_fx + 128 + 4; by = m_fy + 32 + 2;
        bullet_left = 12'(bx); bullet_right = 12'(bx + 2);
        bullet_top = 12'(by); bullet_bottom = 12'(by + 2);
        bullet_active = 1'b1;
        fsync = 1'b1; tick; fsync = 1'b0; model_motion();
        pulses = 0; lat = -1;
        for (int c = 1; c < 10; c++) begin tick; if (bullet_hit === 1'b1) pulses++; end
        check("restart first pass pulses", 32'(pulses), 32'd0);
        fsync = 1'b1; tick; fsync = 1'b0; model_motion();
        for (int c = 1; c <= 40; c++) begin
            tick;
            if (bullet_hit === 1'b1) begin pulses++; if (lat < 0) lat = c; end
        end
        check("restart pulses",  32'(pulses), 32'd1);
        check("restart latency", 32'(lat),    32'd22);
        m_alive[20] = 1'b0; m_score++;
        check("restart score", 32'(score), 32'd3);

        // Kill the rest one per frame
        for (int k = 0; k < 32; k++) begin
            if (m_alive[k]) begin
                check("not yet clear", 32'(all_clear), 32'd0);
                run_frame($sformatf("kill %0d", k), m_fx + 32*(k%8), m_fx + 32*(k%8),
                          m_fy + 16*(k/8), m_fy + 16*(k/8), 1'b1);
            end
        end
        check("all_clear", 32'(all_clear), 32'd1);
        check("final score", 32'(score), 32'd32);
        fx_before = dut.r_form_x;
        quick_frame(); quick_frame(); quick_frame();
        check("frozen form_x", 32'(dut.r_form_x), 32'(m_fx));
        check("frozen vs before", 32'(dut.r_form_x), 32'(fx_before));

        // March until the invasion line is reached, then confirm the freeze
        do_reset();
        for (int f = 0; f < 20000 && !m_invaded(); f++) begin
            quick_frame();
            check("invaded track", 32'(invaded), 32'(m_invaded()));
        end
        check("invaded final", 32'(invaded), 32'd1);
        check_pos("invaded pos", m_fx, m_fy);
        quick_frame(); quick_frame();
        check_pos("invaded frozen pos", m_fx, m_fy);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
